// File: rtl/crc5_d64_checker_pkg.sv
// -----------------------------------------------------------------------------
// crc5_d64_checker_pkg
// Shared definitions for the 64-bit CRC-5 (x^5 + x^2 + 1) transmit generator
// and receive checker. Both ends call crc5_d64() so they always use the same
// parallel matrix.
//
// Contents:
//   CRC5_W, DATA_W, CRC5_POLY : widths and polynomial taps (x^2 + 1)
//   s1_beat_t                 : payload + received CRC held in stage 1
//   s2_beat_t                 : payload + mismatch flag held in stage 2
//   crc5_d64()                : CRC of one 64-bit word, MSB first, init 0
// -----------------------------------------------------------------------------
package crc5_d64_checker_pkg;

  localparam int CRC5_W = 5;
  localparam int DATA_W = 64;
  localparam logic [CRC5_W-1:0] CRC5_POLY = 5'b00101;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CRC5_W-1:0] crc;
  } s1_beat_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
  } s2_beat_t;

  // Written as a bit-serial LFSR over all 64 bits; synthesis flattens the
  // loop into a pure XOR tree (D(x)*x^5 mod P, no reflection, no final XOR).
  function automatic logic [CRC5_W-1:0] crc5_d64(input logic [DATA_W-1:0] data);
    logic [CRC5_W-1:0] crc;
    logic              fb;
    crc = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb  = crc[CRC5_W-1] ^ data[i];
      crc = {crc[CRC5_W-2:0], 1'b0} ^ ({CRC5_W{fb}} & CRC5_POLY);
    end
    return crc;
  endfunction

endpackage

// File: rtl/crc5_d64_checker_pipe_stage.sv
// -----------------------------------------------------------------------------
// crc5_d64_pipe_stage
// One valid/ready register slice. Accepts a word whenever it is empty or its
// current word leaves this cycle, so a chain of slices sustains one word per
// cycle. in_ready_o is combinational from out_ready_i (never from in_valid_i).
//
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   in_valid_i/in_ready_o/in_data_i    : upstream handshake and word
//   out_valid_o/out_ready_i/out_data_o : downstream handshake and word
// -----------------------------------------------------------------------------
module crc5_d64_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         load;

  assign in_ready_o = !valid_q || out_ready_i;
  assign load       = in_valid_i && in_ready_o;

  // Data only changes on a load, so it stays stable while stalled.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/crc5_d64_checker.sv
// -----------------------------------------------------------------------------
// crc5_d64_checker
// Receive-side CRC-5 checker for 64-bit beats. Two register slices with the
// CRC XOR tree between them; stage 2 carries the payload and a mismatch flag.
// Keeps a saturating bad-beat counter and a sticky flag; optionally discards
// bad beats at stage 2 without ever stalling on them.
//
// Parameters:
//   CNT_W    : error counter width
//   DROP_BAD : 1 = mismatching beats are dropped at stage 2
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   s_valid/s_ready/s_data/s_crc : input beat and received CRC
//   m_valid/m_ready/m_data/m_crc_err : output beat and mismatch flag
//   clr_err                    : sync clear of err_cnt / err_seen (wins)
//   err_cnt, err_seen          : status: retired bad beats, sticky flag
// -----------------------------------------------------------------------------
module crc5_d64_checker
  import crc5_d64_checker_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter bit DROP_BAD = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [63:0]       s_data,
  input  logic [4:0]        s_crc,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [63:0]       m_data,
  output logic              m_crc_err,
  input  logic              clr_err,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              err_seen
);

  s1_beat_t s1_in, s1_beat;
  s2_beat_t s2_in, s2_beat;
  logic     s1_valid, s2_in_ready;
  logic     s2_valid, s2_out_ready, s2_drop;
  logic [CRC5_W-1:0] crc_calc;
  logic     bad_retire;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             seen_q, seen_d;

  assign s1_in = '{data: s_data, crc: s_crc};

  crc5_d64_pipe_stage #(.W($bits(s1_beat_t))) u_s1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (s_valid),
    .in_ready_o  (s_ready),
    .in_data_i   (s1_in),
    .out_valid_o (s1_valid),
    .out_ready_i (s2_in_ready),
    .out_data_o  (s1_beat)
  );

  // Recompute between the slices; stage 2 stores only the verdict.
  assign crc_calc = crc5_d64(s1_beat.data);
  assign s2_in    = '{data: s1_beat.data, err: (crc_calc != s1_beat.crc)};

  // A dropped beat leaves stage 2 unconditionally, so m_ready is irrelevant
  // for it and it never blocks the beat behind.
  assign s2_drop      = DROP_BAD && s2_beat.err;
  assign s2_out_ready = m_ready || s2_drop;

  crc5_d64_pipe_stage #(.W($bits(s2_beat_t))) u_s2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (s1_valid),
    .in_ready_o  (s2_in_ready),
    .in_data_i   (s2_in),
    .out_valid_o (s2_valid),
    .out_ready_i (s2_out_ready),
    .out_data_o  (s2_beat)
  );

  assign m_valid   = s2_valid && !s2_drop;
  assign m_data    = s2_beat.data;
  assign m_crc_err = s2_beat.err;

  // A bad beat "retires" either on the m_* handshake or by being dropped.
  assign bad_retire = s2_valid && s2_beat.err && s2_out_ready;

  always_comb begin
    cnt_d  = cnt_q;
    seen_d = seen_q;
    if (clr_err) begin
      cnt_d  = '0;
      seen_d = 1'b0;
    end else if (bad_retire) begin
      seen_d = 1'b1;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      seen_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      seen_q <= seen_d;
    end
  end

  assign err_cnt  = cnt_q;
  assign err_seen = seen_q;

endmodule

// File: tb/tb_crc5_d64_checker.sv
// -----------------------------------------------------------------------------
// tb_crc5_d64_checker
// Three checker instances: A (default), B (DROP_BAD=1), C (CNT_W=2). A shared
// driver feeds the instance chosen by sel; expected output beats go into a
// per-instance queue and a negedge monitor pops and compares on m_* handshakes.
// -----------------------------------------------------------------------------
module tb_crc5_d64_checker;

  typedef struct packed {
    logic [63:0] data;
    logic        err;
    logic [31:0] cyc;
    logic        lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        drv_valid;
  logic [63:0] drv_data;
  logic [4:0]  drv_crc;
  int          sel;

  logic [2:0]  sv, sr, mv, me, mr, clr, seen;
  logic [63:0] md [3];
  logic [15:0] cnt_a, cnt_b;
  logic [1:0]  cnt_c;

  exp_t qa[$], qb[$], qc[$];
  int   nchk = 0, nerr = 0;
  int   cyc = 0;
  int   acc = 0, stall_waits = 0;
  exp_t mon_x;
  bit   mon_empty;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign sv[0] = drv_valid && (sel == 0);
  assign sv[1] = drv_valid && (sel == 1);
  assign sv[2] = drv_valid && (sel == 2);

  crc5_d64_checker #(.CNT_W(16), .DROP_BAD(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .s_valid(sv[0]), .s_ready(sr[0]), .s_data(drv_data),
    .s_crc(drv_crc), .m_valid(mv[0]), .m_ready(mr[0]), .m_data(md[0]),
    .m_crc_err(me[0]), .clr_err(clr[0]), .err_cnt(cnt_a), .err_seen(seen[0]));

  crc5_d64_checker #(.CNT_W(16), .DROP_BAD(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .s_valid(sv[1]), .s_ready(sr[1]), .s_data(drv_data),
    .s_crc(drv_crc), .m_valid(mv[1]), .m_ready(mr[1]), .m_data(md[1]),
    .m_crc_err(me[1]), .clr_err(clr[1]), .err_cnt(cnt_b), .err_seen(seen[1]));

  crc5_d64_checker #(.CNT_W(2), .DROP_BAD(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .s_valid(sv[2]), .s_ready(sr[2]), .s_data(drv_data),
    .s_crc(drv_crc), .m_valid(mv[2]), .m_ready(mr[2]), .m_data(md[2]),
    .m_crc_err(me[2]), .clr_err(clr[2]), .err_cnt(cnt_c), .err_seen(seen[2]));

  // Reference CRC by polynomial long division of D(x)*x^5.
  function automatic logic [4:0] model_crc(input logic [63:0] d);
    logic [68:0] r;
    r = {d, 5'b0};
    for (int i = 68; i >= 5; i--) begin
      if (r[i]) r[i -: 6] = r[i -: 6] ^ 6'b100101;
    end
    return r[4:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one beat on the selected instance; push its expected output on
  // acceptance. Leaves s_valid high so consecutive calls stream back to back.
  task automatic send(input logic [63:0] d, input logic [4:0] c, input logic e, input logic lat);
    bit   done;
    exp_t x;
    done = 0;
    drv_data = d; drv_crc = c; drv_valid = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (sr[sel]) begin
        x.data = d; x.err = e; x.cyc = cyc; x.lat = lat;
        case (sel)
          0: qa.push_back(x);
          1: if (!e) qb.push_back(x);
          default: qc.push_back(x);
        endcase
        acc++;
        done = 1;
      end else begin
        stall_waits++;
      end
    end
    nchk++;
    if (!done) begin
      nerr++;
      drv_valid = 1'b0;
      $display("FAIL send_timeout: inst %0d beat %h not accepted within 40 cycles", sel, d);
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        if (mv[i] && mr[i]) begin
          mon_empty = 1'b0;
          case (i)
            0: begin mon_empty = (qa.size() == 0); if (!mon_empty) mon_x = qa.pop_front(); end
            1: begin mon_empty = (qb.size() == 0); if (!mon_empty) mon_x = qb.pop_front(); end
            default: begin mon_empty = (qc.size() == 0); if (!mon_empty) mon_x = qc.pop_front(); end
          endcase
          if (mon_empty) begin
            nchk++; nerr++;
            $display("FAIL mon_unexpected: inst %0d output %h with empty queue", i, md[i]);
          end else begin
            chk("mon_data", md[i], mon_x.data);
            chk("mon_err", {63'd0, me[i]}, {63'd0, mon_x.err});
            if (mon_x.lat) chk("mon_latency", 64'(cyc - int'(mon_x.cyc)), 64'd2);
            $display("inst %0d out data=%h err=%0d", i, md[i], me[i]);
          end
        end
      end
      if (mv[1]) chk("drop_leak", {63'd0, me[1]}, 64'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [63:0] vd [5];
    logic [4:0]  vc [5];
    logic        ve [5];
    logic [63:0] rd;
    logic [63:0] ref_d;
    bit          have;
    int          acc0;

    vd[0] = 64'h0; vc[0] = 5'h00; ve[0] = 1'b0;
    vd[1] = 64'h1; vc[1] = 5'h05; ve[1] = 1'b0;
    vd[2] = 64'h2; vc[2] = 5'h0A; ve[2] = 1'b0;
    vd[3] = 64'h8; vc[3] = 5'h0D; ve[3] = 1'b0;
    vd[4] = 64'h1; vc[4] = 5'h04; ve[4] = 1'b1;

    rst_n = 1'b0; drv_valid = 1'b0; drv_data = '0; drv_crc = '0; sel = 0;
    mr = 3'b111; clr = 3'b000;
    repeat (3) @(negedge clk);
    chk("rst_m_valid", {63'd0, mv[0]}, 64'd0);
    chk("rst_m_data", md[0], 64'd0);
    chk("rst_m_crc_err", {63'd0, me[0]}, 64'd0);
    chk("rst_err_cnt", {48'd0, cnt_a}, 64'd0);
    chk("rst_err_seen", {63'd0, seen[0]}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_s_ready", {63'd0, sr[0]}, 64'd1);
    @(posedge clk); #1;

    // Known vectors on A, 2-cycle latency checked by the monitor.
    for (int i = 0; i < 4; i++) send(vd[i], vc[i], ve[i], 1'b1);
    drv_valid = 1'b0;
    cycles(4);
    chk("vec_cnt_clean", {48'd0, cnt_a}, 64'd0);
    send(vd[4], vc[4], ve[4], 1'b1);
    drv_valid = 1'b0;
    cycles(4);
    chk("vec_cnt_bad", {48'd0, cnt_a}, 64'd1);
    chk("vec_seen_bad", {63'd0, seen[0]}, 64'd1);

    clr[0] = 1'b1; cycles(1); clr[0] = 1'b0;
    chk("clr_cnt", {48'd0, cnt_a}, 64'd0);
    chk("clr_seen", {63'd0, seen[0]}, 64'd0);

    // 100 back-to-back random good beats.
    stall_waits = 0;
    for (int i = 0; i < 100; i++) begin
      rd = {$urandom, $urandom};
      send(rd, model_crc(rd), 1'b0, 1'b1);
    end
    drv_valid = 1'b0;
    chk("stream_no_stall", 64'(stall_waits), 64'd0);
    cycles(4);
    chk("stream_cnt", {48'd0, cnt_a}, 64'd0);
    chk("stream_drained", 64'(qa.size()), 64'd0);

    // Backpressure: m_ready low for 5 cycles starting with an empty pipe.
    acc0 = acc;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          rd = 64'hA5A5_0000_0000_0000 | 64'(i);
          send(rd, model_crc(rd), 1'b0, 1'b0);
        end
        drv_valid = 1'b0;
      end
      begin
        have = 0;
        ref_d = '0;
        mr[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          if (mv[0]) begin
            if (!have) begin ref_d = md[0]; have = 1; end
            else chk("bp_hold", md[0], ref_d);
          end
        end
        chk("bp_s_ready_low", {63'd0, sr[0]}, 64'd0);
        chk("bp_buffered", 64'(acc - acc0), 64'd2);
        @(posedge clk); #1;
        mr[0] = 1'b1;
      end
    join
    cycles(6);
    chk("bp_drained", 64'(qa.size()), 64'd0);

    // Drop mode: bad/good/bad with m_ready low on B.
    sel = 1;
    mr[1] = 1'b0;
    send(64'h1, 5'h04, 1'b1, 1'b0);
    send(64'h2, 5'h0A, 1'b0, 1'b0);
    send(64'h8, 5'h00, 1'b1, 1'b0);
    drv_valid = 1'b0;
    cycles(3);
    @(negedge clk);
    chk("drop_m_valid", {63'd0, mv[1]}, 64'd1);
    chk("drop_m_data", md[1], 64'h2);
    chk("drop_cnt1", {48'd0, cnt_b}, 64'd1);
    chk("drop_seen", {63'd0, seen[1]}, 64'd1);
    chk("drop_s_ready", {63'd0, sr[1]}, 64'd0);
    @(posedge clk); #1;
    mr[1] = 1'b1;
    send(64'h0, 5'h00, 1'b0, 1'b0);
    drv_valid = 1'b0;
    cycles(5);
    chk("drop_cnt2", {48'd0, cnt_b}, 64'd2);
    chk("drop_drained", 64'(qb.size()), 64'd0);

    // Saturation (CNT_W=2) and clear-wins on C.
    sel = 2;
    for (int i = 0; i < 5; i++) send(64'h1, 5'h04, 1'b1, 1'b1);
    drv_valid = 1'b0;
    cycles(4);
    chk("sat_cnt", {62'd0, cnt_c}, 64'd3);
    chk("sat_seen", {63'd0, seen[2]}, 64'd1);
    send(64'h1, 5'h04, 1'b1, 1'b1);
    drv_valid = 1'b0;
    cycles(1);
    clr[2] = 1'b1;
    @(negedge clk);
    chk("clr_coincide_valid", {63'd0, mv[2]}, 64'd1);
    @(posedge clk); #1;
    clr[2] = 1'b0;
    @(negedge clk);
    chk("clr_wins_cnt", {62'd0, cnt_c}, 64'd0);
    chk("clr_wins_seen", {63'd0, seen[2]}, 64'd0);
    @(posedge clk); #1;

    // Async reset with both stages full and m_ready low on A.
    sel = 0;
    mr[0] = 1'b0;
    send(64'h1111, model_crc(64'h1111), 1'b0, 1'b0);
    send(64'h2222, model_crc(64'h2222), 1'b0, 1'b0);
    drv_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_m_valid", {63'd0, mv[0]}, 64'd1);
    chk("pre_rst_s_ready", {63'd0, sr[0]}, 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_m_valid", {63'd0, mv[0]}, 64'd0);
    chk("async_m_data", md[0], 64'd0);
    qa.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    mr[0] = 1'b1;
    @(negedge clk);
    chk("post_rst_s_ready", {63'd0, sr[0]}, 64'd1);
    chk("post_rst_m_valid", {63'd0, mv[0]}, 64'd0);
    chk("post_rst_cnt_a", {48'd0, cnt_a}, 64'd0);
    chk("post_rst_cnt_b", {48'd0, cnt_b}, 64'd0);
    chk("post_rst_seen_b", {63'd0, seen[1]}, 64'd0);
    cycles(4);

    chk("final_qa", 64'(qa.size()), 64'd0);
    chk("final_qb", 64'(qb.size()), 64'd0);
    chk("final_qc", 64'(qc.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
